// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC generator: redirect priority classes and default reset vector.
package pc_pkg;

    // Encoding order is the priority order; higher value wins.
    typedef enum logic [1:0] {
        RC_SEQ   = 2'd0,
        RC_JUMP  = 2'd1,
        RC_REDIR = 2'd2,
        RC_TRAP  = 2'd3
    } redir_class_e;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_3000;

endpackage

// File: rtl/pc_fetch_if.sv
// Redirect requests from the pipeline into fetch, and the fetch PC/RAS status coming back.
interface pc_fetch_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    logic                         stall_f;
    logic                         trap_valid;
    logic [XLEN-1:0]              trap_target;
    logic                         redir_valid;
    logic [XLEN-1:0]              redir_target;
    logic                         jump_valid;
    logic [XLEN-1:0]              jump_target;
    logic                         call_push;
    logic [XLEN-1:0]              push_addr;
    logic                         ret_pop;
    logic [XLEN-1:0]              pc;
    logic                         pc_misalign;
    logic                         ras_miss;
    logic [$clog2(RAS_DEPTH):0]   ras_count;

    modport master (
        output stall_f, trap_valid, trap_target, redir_valid, redir_target,
               jump_valid, jump_target, call_push, push_addr, ret_pop,
        input  pc, pc_misalign, ras_miss, ras_count
    );

    modport slave (
        input  stall_f, trap_valid, trap_target, redir_valid, redir_target,
               jump_valid, jump_target, call_push, push_addr, ret_pop,
        output pc, pc_misalign, ras_miss, ras_count
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; push/pop/clear take effect on the next edge, top is combinational.
// No backpressure: a push when full overwrites the oldest entry, a pop when empty is ignored.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [XLEN-1:0]          push_addr,
    output logic [XLEN-1:0]          top,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic            pop_ok;

    // ptr names the next free slot, so the top lives one below it.
    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign pop_ok  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop_ok) begin
            mem[top_idx] <= push_addr;
        end else if (push) begin
            mem[ptr] <= push_addr;
            ptr      <= ptr + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop_ok) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC generator: trap > EX redirect > ID jump/return > sequential; 1-edge latency to pc.
// While stall_f is high pc holds and the strongest redirect is parked in a pending latch.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_fetch_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic            misalign_q;
    redir_class_e    pend_class;
    logic [XLEN-1:0] pend_target;

    redir_class_e    new_class;
    logic [XLEN-1:0] new_target;
    logic [XLEN-1:0] pc_next;
    logic            take_new;
    logic [XLEN-1:0] ras_top;
    logic [CW-1:0]   ras_count;
    logic            ras_has;

    assign ras_has = (ras_count != '0);

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.trap_valid),
        .push      (bus.call_push),
        .pop       (bus.ret_pop),
        .push_addr (bus.push_addr),
        .top       (ras_top),
        .count     (ras_count)
    );

    // An explicit jump target beats the RAS prediction when both fire.
    always_comb begin
        new_class  = RC_SEQ;
        new_target = ras_top;
        if (bus.trap_valid) begin
            new_class  = RC_TRAP;
            new_target = bus.trap_target;
        end else if (bus.redir_valid) begin
            new_class  = RC_REDIR;
            new_target = bus.redir_target;
        end else if (bus.jump_valid) begin
            new_class  = RC_JUMP;
            new_target = bus.jump_target;
        end else if (bus.ret_pop && ras_has) begin
            new_class  = RC_JUMP;
            new_target = ras_top;
        end
    end

    // Equal class goes to the new request: it is the younger one.
    assign take_new = (new_class != RC_SEQ) && (new_class >= pend_class);

    always_comb begin
        pc_next = pc_q + XLEN'(INC);
        if (take_new) begin
            pc_next = new_target;
        end else if (pend_class != RC_SEQ) begin
            pc_next = pend_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            misalign_q  <= (RESET_VEC[1:0] != 2'b00);
            pend_class  <= RC_SEQ;
            pend_target <= '0;
        end else if (bus.stall_f) begin
            if (take_new) begin
                pend_class  <= new_class;
                pend_target <= new_target;
            end
        end else begin
            pc_q       <= pc_next;
            misalign_q <= (pc_next[1:0] != 2'b00);
            pend_class <= RC_SEQ;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_misalign = misalign_q;
    assign bus.ras_miss    = bus.ret_pop && !ras_has;
    assign bus.ras_count   = ras_count;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expected PCs and RAS state.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_fetch_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

    pc_fetch_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_3000),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_f      = 1'b0;
        bus.trap_valid   = 1'b0;
        bus.trap_target  = '0;
        bus.redir_valid  = 1'b0;
        bus.redir_target = '0;
        bus.jump_valid   = 1'b0;
        bus.jump_target  = '0;
        bus.call_push    = 1'b0;
        bus.push_addr    = '0;
        bus.ret_pop      = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] a);
        bus.call_push = 1'b1;
        bus.push_addr = a;
        step();
        bus.call_push = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        bus.jump_valid  = 1'b1;
        bus.jump_target = a;
        step();
        bus.jump_valid  = 1'b0;
    endtask

    logic [31:0] pop_exp [4] = '{32'h500, 32'h400, 32'h300, 32'h200};
    logic [31:0] push_vec [5] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_pc", bus.pc, 64'h3000);
        check("reset_misalign", bus.pc_misalign, 0);
        check("reset_ras_count", bus.ras_count, 0);
        step();
        check("seq_1", bus.pc, 64'h3004);
        step();
        check("seq_2", bus.pc, 64'h3008);
        step();
        check("seq_3", bus.pc, 64'h300C);

        // All three redirect sources together; trap wins and wipes the RAS.
        push_one(32'h111);
        check("push_count", bus.ras_count, 1);
        bus.jump_valid = 1'b1;  bus.jump_target  = 32'h4000;
        bus.redir_valid = 1'b1; bus.redir_target = 32'h5000;
        bus.trap_valid = 1'b1;  bus.trap_target  = 32'h8000;
        step();
        idle();
        check("trap_pc", bus.pc, 64'h8000);
        check("trap_ras_clear", bus.ras_count, 0);

        // Redirect then lower-class jump while stalled: redirect survives.
        bus.stall_f = 1'b1;
        bus.redir_valid = 1'b1; bus.redir_target = 32'h5000;
        step();
        bus.redir_valid = 1'b0;
        check("stall_hold_1", bus.pc, 64'h8000);
        bus.jump_valid = 1'b1; bus.jump_target = 32'h4000;
        step();
        bus.jump_valid = 1'b0;
        check("stall_hold_2", bus.pc, 64'h8000);
        step();
        check("stall_hold_3", bus.pc, 64'h8000);
        bus.stall_f = 1'b0;
        step();
        check("stall_release", bus.pc, 64'h5000);

        // Pending jump beaten by a new redirect in the release cycle.
        bus.stall_f = 1'b1;
        jump_to(32'h4000);
        check("pend_hold", bus.pc, 64'h5000);
        bus.stall_f = 1'b0;
        bus.redir_valid = 1'b1; bus.redir_target = 32'h6000;
        step();
        bus.redir_valid = 1'b0;
        check("new_beats_pend", bus.pc, 64'h6000);
        step();
        check("pend_cleared", bus.pc, 64'h6004);

        // Same-class requests while stalled: the newer one is kept.
        bus.stall_f = 1'b1;
        jump_to(32'h4000);
        jump_to(32'h4100);
        bus.stall_f = 1'b0;
        step();
        check("pend_newer", bus.pc, 64'h4100);

        // Overfill the RAS, then drain it.
        for (int i = 0; i < 5; i++) push_one(push_vec[i]);
        check("ras_full", bus.ras_count, 4);
        bus.ret_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ras_hit", bus.ras_miss, 0);
            step();
            check("pop_pc", bus.pc, {32'h0, pop_exp[i]});
        end
        check("ras_empty", bus.ras_count, 0);
        #1;
        check("ras_miss", bus.ras_miss, 1);
        step();
        bus.ret_pop = 1'b0;
        check("miss_seq", bus.pc, 64'h204);

        // Push and pop together: redirect to the old top, top replaced.
        push_one(32'hA00);
        push_one(32'hB00);
        bus.call_push = 1'b1; bus.push_addr = 32'hC00; bus.ret_pop = 1'b1;
        step();
        bus.call_push = 1'b0;
        check("pushpop_pc", bus.pc, 64'hB00);
        check("pushpop_count", bus.ras_count, 2);
        step();
        check("pushpop_top", bus.pc, 64'hC00);
        step();
        bus.ret_pop = 1'b0;
        check("pushpop_next", bus.pc, 64'hA00);

        // Jump and return together: jump target wins, pop still happens.
        push_one(32'hD00);
        bus.ret_pop = 1'b1;
        jump_to(32'h7000);
        bus.ret_pop = 1'b0;
        check("jump_over_ret", bus.pc, 64'h7000);
        check("jump_ret_count", bus.ras_count, 0);

        // Address wrap and misalignment flag.
        jump_to(32'hFFFF_FFFC);
        check("pre_wrap", bus.pc, 64'hFFFF_FFFC);
        step();
        check("wrap", bus.pc, 64'h0);
        jump_to(32'h4002);
        check("misalign_pc", bus.pc, 64'h4002);
        check("misalign_set", bus.pc_misalign, 1);
        jump_to(32'h4000);
        check("misalign_clr", bus.pc_misalign, 0);

        // Reset in the middle of a stall discards the pending redirect.
        bus.stall_f = 1'b1;
        bus.redir_valid = 1'b1; bus.redir_target = 32'h9000;
        push_one(32'h1);
        bus.redir_valid = 1'b0;
        check("pre_rst_count", bus.ras_count, 1);
        rst = 1'b1;
        step();
        check("midrst_pc", bus.pc, 64'h3000);
        check("midrst_count", bus.ras_count, 0);
        rst = 1'b0;
        bus.stall_f = 1'b0;
        step();
        check("midrst_no_pend", bus.pc, 64'h3004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
